// File: rtl/pc_seq.sv
// Program-counter sequencer: picks the next fetch address from increment, branch,
// call or return, with a return-address stack and stall/halt freezing of fetch.
module pc_seq #(
  parameter int          PC_W        = 9,
  parameter int          TGT_W       = 8,
  parameter int          STACK_DEPTH = 4,
  parameter int unsigned START_ADDR  = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               stall,
  input  logic                               halt_req,
  input  logic                               br_en,
  input  logic                               cond,
  input  logic                               br_rel,
  input  logic                               call,
  input  logic                               ret,
  input  logic [TGT_W-1:0]                   target,
  output logic [PC_W-1:0]                    PC,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
  output logic                               halted,
  output logic                               stack_ovf,
  output logic                               stack_unf
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   stack [STACK_DEPTH];
  logic [PC_W-1:0]   pc_nxt, pc_inc, tos, rel_off;
  logic [SP_W-1:0]   sp_nxt;
  logic              push_en, ovf_nxt, unf_nxt;
  logic signed [TGT_W-1:0] tgt_s;

  assign pc_inc  = PC + PC_W'(1);
  assign tgt_s   = target;
  // Size cast of a signed operand sign-extends the relative offset.
  assign rel_off = PC_W'(tgt_s);
  assign halted  = (state == S_HALT);

  // Top-of-stack read: entry sp-1, selected without narrowing sp.
  always_comb begin
    tos = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (SP_W'(i + 1) == sp) tos = stack[i];
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    sp_nxt    = sp;
    push_en   = 1'b0;
    ovf_nxt   = stack_ovf;
    unf_nxt   = stack_unf;
    if (state == S_RUN && !stall) begin
      if (halt_req) begin
        state_nxt = S_HALT;
      end else if (ret) begin
        if (sp != '0) begin
          pc_nxt = tos;
          sp_nxt = sp - SP_W'(1);
        end else begin
          unf_nxt = 1'b1;
          pc_nxt  = pc_inc;
        end
      end else if (call) begin
        pc_nxt = PC_W'(target);
        if (sp == SP_W'(STACK_DEPTH)) begin
          ovf_nxt = 1'b1;
        end else begin
          push_en = 1'b1;
          sp_nxt  = sp + SP_W'(1);
        end
      end else if (br_en && cond) begin
        pc_nxt = br_rel ? (PC + rel_off) : PC_W'(target);
      end else begin
        pc_nxt = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RUN;
      PC        <= PC_W'(START_ADDR);
      sp        <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      state     <= state_nxt;
      PC        <= pc_nxt;
      sp        <= sp_nxt;
      stack_ovf <= ovf_nxt;
      stack_unf <= unf_nxt;
    end
  end

  // Stack contents need no reset; only sp defines which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push_en && sp == SP_W'(i)) stack[i] <= pc_inc;
    end
  end

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-counter sequencer for the 9-bit CPU family; it replaces the fixed single-mode PC with a next-generation fetch address generator. Each clock it selects the next instruction address from increment, absolute branch, PC-relative branch, subroutine call or return. A hardware return-address stack supports calls, and stall and halt controls allow the control unit to freeze fetch. It sits between the decode/control unit and instruction memory; its `PC` output drives the instruction ROM address directly.

## Interface
Parameters:
- PC_W, 9: program counter width in bits.
- TGT_W, 8: width of `target`. Must satisfy TGT_W ≤ PC_W.
- STACK_DEPTH, 4: number of return-address stack entries. Must be ≥ 1.
- START_ADDR, 0: PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high; clock clk.
- stall  in  1  hold all state this cycle; all other requests are ignored.
- halt_req  in  1  enter the halted state.
- br_en  in  1  branch instruction present.
- cond  in  1  branch condition from the ALU; the branch is taken when br_en && cond.
- br_rel  in  1  1 = PC-relative branch (signed offset), 0 = absolute branch.
- call  in  1  subroutine call to absolute target.
- ret  in  1  return to the address on top of the stack.
- target  in  TGT_W  branch/call address or signed relative offset.
- PC  out  PC_W  current fetch address (register).
- sp  out  $clog2(STACK_DEPTH+1)  current stack occupancy, 0..STACK_DEPTH.
- halted  out  1  PC is frozen until reset.
- stack_ovf  out  1  sticky flag: a call was made with the stack full.
- stack_unf  out  1  sticky flag: a return was made with the stack empty.

## Operation
- Next-state priority, highest first: reset > halted > stall > halt_req > ret > call > taken branch > increment.
- Reset: PC=START_ADDR, sp=0, halted=0, stack_ovf=0, stack_unf=0. Stack contents are don't-care.
- Halted: PC, sp and the stack hold; every input except reset is ignored; only reset clears `halted`.
- Stall: all registers hold; requests presented in a stalled cycle are dropped, not queued.
- halt_req (not stalled): PC holds; halted=1 from the next cycle.
- Return:
  - sp>0: PC=stack[sp-1], sp decrements.
  - sp==0: stack_unf=1 (sticky), PC=PC+1, sp stays 0.
- Call:
  - Pushes PC+1 (mod 2^PC_W) into stack[sp] and sets PC=zero-extended target; sp increments.
  - When sp==STACK_DEPTH: no push, stack_ovf=1 (sticky), sp unchanged, jump still taken.
- Taken branch:
  - br_rel=0: PC=zero-extended target.
  - br_rel=1: PC=PC+sign-extended target, modulo 2^PC_W.
- Untaken branch or no request: PC=PC+1, wrapping from 2^PC_W−1 to 0.
- Lower-priority requests in the same cycle as a higher-priority one are discarded. For example, ret+call acts as ret only.
- Arithmetic is unsigned PC_W-bit with silent wrap; the relative offset spans −2^(TGT_W−1)..2^(TGT_W−1)−1.

## Timing
- All outputs are registered. Inputs sampled at edge N take effect at edge N, visible after it; there is no combinational path from input to output.
- Latency from a branch/call/ret request to the new PC is one cycle. There are no delay slots and no bubbles inside the block.
- Reset asserted mid-sequence, including while halted or stalled, wins in the same edge. The first post-reset fetch address is START_ADDR.
- stack_ovf and stack_unf assert on the edge of the offending request and stay high until reset.
- sp updates on the same edge as PC.

## Test plan
- Reset then 5 idle cycles -> PC 0,1,2,3,4,5; flags 0; sp=0. Run from 511 with PC_W=9 -> next PC=0.
- Branch at PC=10:
  - br_en=1, cond=1, br_rel=1, target=8'hFC -> PC=6.
  - Same with br_rel=0, target=8'h40 -> PC=64.
  - cond=0 -> PC=11.
- Nested calls:
  - At PC=5 call target=20 -> PC=20, sp=1.
  - At PC=22 call target=40 -> PC=40, sp=2.
  - ret -> PC=23; ret -> PC=6; sp=0.
- Stack limits with STACK_DEPTH=4:
  - 5 consecutive calls -> stack_ovf=1 on the 5th, sp=4, PC=target.
  - 5 returns -> stack_unf=1 on the 5th, PC increments.
- Stall/halt:
  - stall held 3 cycles with call asserted -> PC and sp unchanged, call dropped.
  - halt_req -> PC frozen and halted=1 until reset.
  - reset while halted -> PC=START_ADDR, halted=0.
- Priority: ret+call+branch in the same cycle with sp=1 -> ret executed only, sp=0.
